// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states,
// extender type codes, funct3 encodings and access-size helpers.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_MDR_LATCH,
    S_WB,
    S_WRITE,
    S_END_ERR
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  localparam logic [3:0] T_LB   = 4'd0;
  localparam logic [3:0] T_LH   = 4'd1;
  localparam logic [3:0] T_LW   = 4'd2;
  localparam logic [3:0] T_LBU  = 4'd3;
  localparam logic [3:0] T_LHU  = 4'd4;
  localparam logic [3:0] T_LWU  = 4'd5;
  localparam logic [3:0] T_SD   = 4'd6;
  localparam logic [3:0] T_SW   = 4'd7;
  localparam logic [3:0] T_SH   = 4'd8;
  localparam logic [3:0] T_SB   = 4'd9;
  localparam logic [3:0] T_LD   = 4'd10;
  localparam logic [3:0] T_IDLE = 4'b1111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // An access is aligned when the address is a multiple of its size.
  function automatic logic misaligned(input lsu_size_e sz, input logic [2:0] a_lo);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a_lo[0];
      SZ_W:    misaligned = (a_lo[1:0] != 2'b00);
      default: misaligned = (a_lo != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Request/strobe bundle between the main control unit (master) and the
// load/store sequencer (slave).
interface load_store_sequencer_if;

  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;

  logic        busy;
  logic        done;
  logic        illegal;
  logic        fault;
  logic        mem_rd;
  logic        mem_wr;
  logic        mdr_load;
  logic        reg_wr;
  logic [3:0]  instr_i_type;

  modport master (
    output start, is_load, is_store, funct3, addr,
    input  busy, done, illegal, fault, mem_rd, mem_wr, mdr_load, reg_wr, instr_i_type
  );

  modport slave (
    input  start, is_load, is_store, funct3, addr,
    output busy, done, illegal, fault, mem_rd, mem_wr, mdr_load, reg_wr, instr_i_type
  );

endinterface

// File: rtl/lsu_type_decode.sv
// Combinational decode of a memory request into the extender type code,
// a legality flag, a read-modify-write flag and the access size.
module lsu_type_decode
  import riscv_lsu_pkg::*;
(
  input  logic       is_load_i,
  input  logic       is_store_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] type_o,
  output logic       legal_o,
  output logic       rmw_o,
  output lsu_size_e  size_o
);

  always_comb begin
    type_o  = T_IDLE;
    legal_o = 1'b0;
    rmw_o   = 1'b0;
    size_o  = lsu_size_e'(funct3_i[1:0]);

    if (is_load_i && !is_store_i) begin
      legal_o = 1'b1;
      case (funct3_i)
        F3_LB:   type_o = T_LB;
        F3_LH:   type_o = T_LH;
        F3_LW:   type_o = T_LW;
        F3_LD:   type_o = T_LD;
        F3_LBU:  type_o = T_LBU;
        F3_LHU:  type_o = T_LHU;
        F3_LWU:  type_o = T_LWU;
        default: legal_o = 1'b0;
      endcase
    end else if (is_store_i && !is_load_i) begin
      legal_o = 1'b1;
      rmw_o   = 1'b1;
      // Only a full doubleword store can skip the merge read.
      case (funct3_i)
        F3_SB:   type_o = T_SB;
        F3_SH:   type_o = T_SH;
        F3_SW:   type_o = T_SW;
        F3_SD: begin
          type_o = T_SD;
          rmw_o  = 1'b0;
        end
        default: begin
          legal_o = 1'b0;
          rmw_o   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer: drives memory strobes, MDR load, register
// write and the extender type code. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_sequencer
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
)
(
  input  logic                  clock,
  input  logic                  reset,
  load_store_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       type_q, type_d;
  logic             ld_q, ld_d;

  logic             busy_q, done_q, illegal_q, fault_q;
  logic             mem_rd_q, mem_wr_q, mdr_load_q, reg_wr_q;
  logic [3:0]       ity_q;

  logic [3:0]       dec_type;
  logic             dec_legal;
  logic             dec_rmw;
  lsu_size_e        dec_size;
  logic             mis_a;
  logic             accept;
  logic             unused_addr;

  lsu_type_decode u_decode (
    .is_load_i  (bus.is_load),
    .is_store_i (bus.is_store),
    .funct3_i   (bus.funct3),
    .type_o     (dec_type),
    .legal_o    (dec_legal),
    .rmw_o      (dec_rmw),
    .size_o     (dec_size)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_a       = misaligned(dec_size, bus.addr[2:0]);
  assign unused_addr = ^{bus.addr[63:3]};
`else
  assign mis_a       = 1'b0;
  assign unused_addr = ^{bus.addr, dec_size};
`endif

  assign accept = (state_q == S_IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    ld_d    = ld_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          type_d = dec_type;
          ld_d   = bus.is_load;
          if (!dec_legal || mis_a) begin
            state_d = S_END_ERR;
          end else if (bus.is_load || dec_rmw) begin
            state_d = S_RD_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ld_q ? S_MDR_LATCH : S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MDR_LATCH: state_d = S_WB;
      S_WB:        state_d = S_IDLE;
      S_WRITE:     state_d = S_IDLE;
      S_END_ERR:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      type_q     <= T_IDLE;
      ld_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mdr_load_q <= 1'b0;
      reg_wr_q   <= 1'b0;
      ity_q      <= T_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      ld_q       <= ld_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d inside {S_WB, S_WRITE, S_END_ERR});
      illegal_q  <= accept && !dec_legal;
      fault_q    <= accept && dec_legal && mis_a;
      mem_rd_q   <= (state_d == S_RD_WAIT);
      mem_wr_q   <= (state_d == S_WRITE);
      mdr_load_q <= (state_d == S_MDR_LATCH);
      reg_wr_q   <= (state_d == S_WB);
      ity_q      <= (state_d == S_IDLE || state_d == S_END_ERR) ? T_IDLE : type_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;
  assign bus.fault        = fault_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mdr_load     = mdr_load_q;
  assign bus.reg_wr       = reg_wr_q;
  assign bus.instr_i_type = ity_q;

endmodule

// File: doc/load_store_sequencer.md
# load_store_sequencer

Multicycle controller that sequences every RISC-V load and store through data memory, MDR and the load/store extender. It accepts one memory instruction from the main control unit and drives the extender's 4-bit type code. It also drives the memory read/write strobes, the MDR load and the register-file write. Sub-word stores are performed as read-modify-write, so that the extender can merge the register byte, half or word into the memory doubleword.

## Interface
- MEM_LATENCY, 1: cycles between a read request and valid data on the data-memory output (≥1).
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  control unit requests a memory op; sampled only in IDLE
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- funct3  input  3  instruction funct3
- addr  input  64  effective address (ALU out); used only for alignment checks
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, operation complete
- illegal  output  1  one-cycle pulse with done, bad encoding
- fault  output  1  one-cycle pulse with done, misaligned access (only when the feature is compiled in)
- mem_rd  output  1  data-memory read strobe
- mem_wr  output  1  data-memory write strobe
- mdr_load  output  1  latch data-memory output into MDR
- reg_wr  output  1  register-file write enable
- instr_i_type  output  4  extender type code

## Operation
- Decode for loads: funct3 000 maps to lb=0. 001 lh=1, 010 lw=2, 011 ld=10, 100 lbu=3, 101 lhu=4, 110 lwu=5. 111 is illegal.
- Decode for stores: funct3 000 maps to sb=9. 001 sh=8, 010 sw=7, 011 sd=6. 1xx is illegal.
- is_load and is_store both high, or both low, with start is illegal.
- States: IDLE, RD_WAIT, MDR_LATCH, WB, WRITE, END_ERR.
- Load path: IDLE → RD_WAIT (mem_rd high, latency counter runs MEM_LATENCY cycles) → MDR_LATCH (mdr_load) → WB (reg_wr, done) → IDLE.
- sd path: IDLE → WRITE (mem_wr, done) → IDLE.
- sb/sh/sw path: IDLE → RD_WAIT (mem_rd, MEM_LATENCY cycles) → WRITE (mem_wr, done) → IDLE.
- Illegal request: IDLE → END_ERR (illegal, done) → IDLE. No strobe is asserted.
- instr_i_type is registered at accept and held constant until the cycle after done. It is 4'b1111 in IDLE and END_ERR.
- At most one of mem_rd, mem_wr, mdr_load and reg_wr is high in any cycle.

## Timing
- Reset values: state IDLE, counter 0, busy=0, done=0, illegal=0, fault=0, mem_rd=0, mem_wr=0, mdr_load=0, reg_wr=0, instr_i_type=4'b1111.
- Accept: start high in IDLE at edge N. busy rises in cycle N+1 and falls the cycle after done.
- Load latency from accept edge to done cycle: MEM_LATENCY+2.
- sd latency: 1 cycle. sb/sh/sw latency: MEM_LATENCY+1. Illegal latency: 1.
- start while busy is ignored and not queued. start in the done cycle is also ignored; the next accept is possible in the following cycle.
- Latency counter counts MEM_LATENCY-1 down to 0, then the FSM advances. It reloads on each RD_WAIT entry.
- Reset mid-operation aborts at the next edge. No further strobes are issued, and the partial RMW is not written.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misalignment is checked at accept. Misaligned means addr[0]≠0 for h, addr[1:0]≠0 for w, addr[2:0]≠0 for d.
- A misaligned request goes IDLE → END_ERR with fault=1 and done=1, no strobes, latency 1.
- LSU_MISALIGN_TRAP_EN undefined: fault is tied 0, addr is unused, and every legal request proceeds normally.

## Structure
- Package riscv_lsu_pkg holds:
  - the state enum;
  - localparams for the eleven type codes (0–10) and the idle code 4'b1111;
  - the load/store opcode funct3 constants.
- Sub-module lsu_type_decode is a combinational block. Inputs: is_load, is_store, funct3. Outputs: type code, legal flag, is_rmw flag, access-size field.
- The FSM, latency counter and output registers live in load_store_sequencer.

## Test plan
- After reset, with MEM_LATENCY=2, a load with funct3=000: instr_i_type=0, mem_rd high for 2 cycles, then mdr_load for 1 cycle, then reg_wr with done 4 cycles after accept.
- Store with funct3=011: instr_i_type=6, mem_wr and done in the single cycle after accept, and mem_rd never asserted.
- Store with funct3=000 (sb), MEM_LATENCY=1: mem_rd for 1 cycle, then mem_wr with done. instr_i_type=9 throughout.
- Load with funct3=111, and separately start with is_load=is_store=1: illegal and done pulse one cycle after accept, with no strobes.
- Second start asserted mid-load, and reset asserted in RD_WAIT: the second start is ignored; after reset all outputs return to reset values next cycle and no mem_wr is issued.
- With LSU_MISALIGN_TRAP_EN, a load with funct3=010 at addr=0x...6: fault and done after 1 cycle, no mem_rd. Without the macro the same request completes as a normal load.
